// File: rtl/hazard_unit_sb.sv
// Hazard/forwarding controller for a 5-stage RISC-V pipeline.
// M/W operand forwarding, load-use stall and branch flush, plus a per-register
// scoreboard for variable-latency long ops (mul/div), an outstanding-op cap,
// a global data-memory freeze and a saturating stall-cycle counter.
module hazard_unit_sb #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 2,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  // D stage
  input  logic [AW-1:0]   rs1d,
  input  logic [AW-1:0]   rs2d,
  input  logic [AW-1:0]   rdd,
  input  logic            regwrite_d,
  input  logic            long_d,
  // E stage
  input  logic [AW-1:0]   rs1e,
  input  logic [AW-1:0]   rs2e,
  input  logic [AW-1:0]   rde,
  input  logic [1:0]      resultsrc_e,
  input  logic            long_e,
  input  logic            pcsrc_e,
  // M stage
  input  logic [AW-1:0]   rdm,
  input  logic            regwrite_m,
  input  logic [1:0]      resultsrc_m,
  // W stage
  input  logic [AW-1:0]   rdw,
  input  logic            regwrite_w,
  // Long-op unit and memory
  input  logic            long_done,
  input  logic [AW-1:0]   long_rd,
  input  logic            mem_wait,
  // Hazard controls
  output logic [1:0]      forward_a_e,
  output logic [1:0]      forward_b_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            stall_m,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_w,
  // Status
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err,
  output logic [CNTW-1:0] stall_cycles
);

  localparam int OCW = $clog2(MAX_OUT + 1);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] r_busy;
  logic [OCW-1:0]  r_out_cnt;
  logic            r_sb_err;
  logic [CNTW-1:0] r_stall_cycles;

  logic            w_lw_stall;
  logic            w_sb_hit;
  logic            w_cap_stall;
  logic            w_hz;
  logic            w_iss;
  logic            w_ret;
  logic [NREG-1:0] w_busy_eff;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [OCW:0]    w_cnt_sum;

  // Forward selection for one E-stage source: M alt result, M ALU, W, regfile.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (rs == rdm && regwrite_m)
        sel = (resultsrc_m == 2'b11) ? 2'b11 : 2'b10;
      else if (rs == rdw && regwrite_w)
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(rs1e);
  assign forward_b_e = fwd_sel(rs2e);

  // Load-use: the loaded value is not available until W, so D must wait a cycle.
  assign w_lw_stall = (resultsrc_e == 2'b01) && (rde != '0) &&
                      ((rs1d == rde) || (rs2d == rde));

  // A register retiring this cycle is written before the regfile is read,
  // so its busy bit no longer blocks D.
  assign w_clr_mask = long_done ? (ONE_HOT0 << long_rd) : '0;
  assign w_busy_eff = r_busy & ~w_clr_mask;

  // Scoreboard hit on sources (RAW) or destination (WAW), including a long op
  // sitting in E that has not yet reached the scoreboard.
  assign w_sb_hit =
      ((rs1d != '0) && w_busy_eff[rs1d]) ||
      ((rs2d != '0) && w_busy_eff[rs2d]) ||
      (regwrite_d && (rdd != '0) && w_busy_eff[rdd]) ||
      (long_e && (rde != '0) &&
       ((rde == rs1d) || (rde == rs2d) || (regwrite_d && (rde == rdd))));

  // A long op in D may not issue while the long unit is already full,
  // counting the one in E that is about to issue.
  assign w_cnt_sum   = {1'b0, r_out_cnt} + {{OCW{1'b0}}, long_e};
  assign w_cap_stall = long_d && (w_cnt_sum >= (OCW+1)'(MAX_OUT));

  assign w_hz = w_lw_stall || w_sb_hit || w_cap_stall;

  // Stage controls: a memory wait freezes everything and defers any flush.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves
    // one unassigned, which would otherwise infer a latch.
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = w_hz;
      stall_d = w_hz;
      flush_d = pcsrc_e;
      flush_e = w_hz || pcsrc_e;
    end
  end

  // Issue happens when the long op leaves E; retire only counts for a busy register.
  assign w_iss      = long_e && !mem_wait && (rde != '0);
  assign w_ret      = long_done && (long_rd != '0) && r_busy[long_rd];
  assign w_set_mask = w_iss ? (ONE_HOT0 << rde) : '0;

  // Scoreboard, outstanding count and sticky error; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_out_cnt <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_busy <= (r_busy & ~(w_ret ? w_clr_mask : '0)) | w_set_mask;
      case ({w_iss, w_ret})
        2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
        2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
        default: r_out_cnt <= r_out_cnt;
      endcase
      if (long_done && !w_ret)
        r_sb_err <= 1'b1;
    end
  end

  // Saturating count of cycles in which fetch is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (stall_f && !(&r_stall_cycles))
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end

  assign busy_vec     = r_busy;
  assign sb_err       = r_sb_err;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Testbench for hazard_unit_sb: directed scenarios followed by random stimulus,
// all compared against a behavioural model of the hazard rules.
module tb_hazard_unit_sb;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int MAX_OUT = 2;
  localparam int CNTW    = 5;   // small so saturation is reachable
  localparam int SC_MAX  = (1 << CNTW) - 1;

  logic            clk, rst;
  logic [AW-1:0]   rs1d, rs2d, rdd, rs1e, rs2e, rde, rdm, rdw, long_rd;
  logic            regwrite_d, long_d, long_e, pcsrc_e, regwrite_m, regwrite_w;
  logic            long_done, mem_wait;
  logic [1:0]      resultsrc_e, resultsrc_m;
  logic [1:0]      forward_a_e, forward_b_e;
  logic            stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [NREG-1:0] busy_vec;
  logic            sb_err;
  logic [CNTW-1:0] stall_cycles;

  hazard_unit_sb #(.NREG(NREG), .AW(AW), .MAX_OUT(MAX_OUT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd), .regwrite_d(regwrite_d), .long_d(long_d),
    .rs1e(rs1e), .rs2e(rs2e), .rde(rde), .resultsrc_e(resultsrc_e),
    .long_e(long_e), .pcsrc_e(pcsrc_e),
    .rdm(rdm), .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m),
    .rdw(rdw), .regwrite_w(regwrite_w),
    .long_done(long_done), .long_rd(long_rd), .mem_wait(mem_wait),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .busy_vec(busy_vec), .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state
  bit m_busy [NREG];
  int m_out;
  bit m_err;
  int m_sc;
  bit m_stall_f;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_out = 0;
    m_err = 1'b0;
    m_sc  = 0;
  endtask

  task automatic clear_inputs();
    rs1d = '0; rs2d = '0; rdd = '0; regwrite_d = 0; long_d = 0;
    rs1e = '0; rs2e = '0; rde = '0; resultsrc_e = 2'b00; long_e = 0; pcsrc_e = 0;
    rdm = '0; regwrite_m = 0; resultsrc_m = 2'b00;
    rdw = '0; regwrite_w = 0;
    long_done = 0; long_rd = '0; mem_wait = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input int rs);
    if (rs == 0) return 2'b00;
    if (rs == int'(rdm) && regwrite_m) return (resultsrc_m == 2'b11) ? 2'b11 : 2'b10;
    if (rs == int'(rdw) && regwrite_w) return 2'b01;
    return 2'b00;
  endfunction

  // Busy as seen by D: x0 never busy, and a register retiring now is already free.
  function automatic bit seen_busy(input int r);
    return (r != 0) && m_busy[r] && !(long_done && int'(long_rd) == r);
  endfunction

  function automatic logic [NREG-1:0] exp_busy_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Compare every output against the rules for the current inputs and state.
  task automatic compare_all();
    bit lw, sb, cap, hz;
    int a, b, d, e;
    a = int'(rs1d); b = int'(rs2d); d = int'(rdd); e = int'(rde);
    lw  = (resultsrc_e == 2'b01) && (e != 0) && (a == e || b == e);
    sb  = seen_busy(a) || seen_busy(b) || (regwrite_d && seen_busy(d)) ||
          (long_e && e != 0 && (e == a || e == b || (regwrite_d && e == d)));
    cap = long_d && ((m_out + (long_e ? 1 : 0)) >= MAX_OUT);
    hz  = lw || sb || cap;
    m_stall_f = mem_wait ? 1'b1 : hz;
    check("fwd_a",    64'(forward_a_e), 64'(ref_fwd(int'(rs1e))));
    check("fwd_b",    64'(forward_b_e), 64'(ref_fwd(int'(rs2e))));
    check("stall_f",  64'(stall_f), 64'(m_stall_f));
    check("stall_d",  64'(stall_d), 64'(m_stall_f));
    check("stall_e",  64'(stall_e), 64'(mem_wait));
    check("stall_m",  64'(stall_m), 64'(mem_wait));
    check("flush_d",  64'(flush_d), 64'(!mem_wait && pcsrc_e));
    check("flush_e",  64'(flush_e), 64'(!mem_wait && (hz || pcsrc_e)));
    check("flush_w",  64'(flush_w), 64'(mem_wait));
    check("busy_vec", 64'(busy_vec), 64'(exp_busy_vec()));
    check("sb_err",   64'(sb_err), 64'(m_err));
    check("stall_cycles", 64'(stall_cycles), 64'(m_sc));
  endtask

  // Advance the reference state across one clock edge.
  task automatic model_update();
    bit iss, ret;
    iss = long_e && !mem_wait && (rde != 0);
    ret = long_done && (long_rd != 0) && m_busy[long_rd];
    if (long_done && !ret) m_err = 1'b1;
    if (ret) m_busy[long_rd] = 1'b0;
    if (iss) m_busy[rde] = 1'b1;
    m_out = m_out + (iss ? 1 : 0) - (ret ? 1 : 0);
    if (m_stall_f && m_sc < SC_MAX) m_sc++;
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  int sc0;
  int pick;
  bit ok;

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_busy", 64'(busy_vec), 64'(0));
    check("rst_err",  64'(sb_err), 64'(0));
    check("rst_sc",   64'(stall_cycles), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Forwarding from M (ALU and alternate result) and x0 suppression
    rdm = 5; regwrite_m = 1; resultsrc_m = 2'b00; rs1e = 5; rs2e = 5;
    settle(); check("fwd_m_alu_a", 64'(forward_a_e), 64'(2'b10));
    check("fwd_m_alu_b", 64'(forward_b_e), 64'(2'b10)); tick();
    resultsrc_m = 2'b11;
    settle(); check("fwd_m_alt_a", 64'(forward_a_e), 64'(2'b11));
    check("fwd_m_alt_b", 64'(forward_b_e), 64'(2'b11)); tick();
    rs1e = 0; rdw = 0; regwrite_w = 1;
    settle(); check("fwd_x0", 64'(forward_a_e), 64'(2'b00)); tick();
    rdm = 6; rdw = 5;
    settle(); check("fwd_w", 64'(forward_b_e), 64'(2'b01)); tick();
    clear_inputs();

    // Load-use stall for one cycle, none for rde=0
    resultsrc_e = 2'b01; rde = 3; rs2d = 3;
    settle(); check("lu_stall", 64'(stall_f), 64'(1));
    check("lu_flush_e", 64'(flush_e), 64'(1)); tick();
    resultsrc_e = 2'b00; rde = 0;
    settle(); check("lu_release", 64'(stall_f), 64'(0)); tick();
    resultsrc_e = 2'b01; rde = 0; rs2d = 0;
    settle(); check("lu_x0", 64'(stall_f), 64'(0)); tick();
    clear_inputs();

    // Scoreboard RAW stall until retirement, with retire-cycle bypass
    long_e = 1; rde = 7;
    cycle();
    long_e = 0; rde = 0; rs1d = 7;
    repeat (3) begin
      settle(); check("sb_stall", 64'(stall_f), 64'(1));
      check("sb_busy7", 64'(busy_vec[7]), 64'(1)); tick();
    end
    long_done = 1; long_rd = 7;
    settle(); check("sb_bypass", 64'(stall_f), 64'(0)); tick();
    clear_inputs();
    settle(); check("sb_clear", 64'(busy_vec), 64'(0)); tick();

    // Outstanding cap, including simultaneous issue and retire
    long_e = 1; rde = 8; cycle();
    rde = 9; cycle();
    long_e = 0; rde = 0; long_d = 1;
    repeat (2) begin
      settle(); check("cap_stall", 64'(stall_f), 64'(1)); tick();
    end
    long_e = 1; rde = 10; long_done = 1; long_rd = 8;
    settle(); check("cap_issret", 64'(stall_f), 64'(1)); tick();
    long_e = 0; rde = 0; long_done = 0;
    settle(); check("cap_cnt_kept", 64'(stall_f), 64'(1));
    check("cap_busy", 64'(busy_vec), 64'((64'(1) << 9) | (64'(1) << 10))); tick();
    long_done = 1; long_rd = 9;
    settle(); check("cap_ret_same", 64'(stall_f), 64'(1)); tick();
    long_done = 0;
    settle(); check("cap_free", 64'(stall_f), 64'(0)); tick();
    long_d = 0; long_done = 1; long_rd = 10; cycle();
    clear_inputs();

    // Memory wait freezes the pipe and defers the branch flush
    sc0 = m_sc;
    pcsrc_e = 1; mem_wait = 1;
    repeat (3) begin
      settle(); check("mw_stall_m", 64'(stall_m), 64'(1));
      check("mw_flush_w", 64'(flush_w), 64'(1));
      check("mw_no_flush_d", 64'(flush_d), 64'(0)); tick();
    end
    mem_wait = 0;
    settle();
    check("mw_sc", 64'(stall_cycles), 64'((sc0 + 3 > SC_MAX) ? SC_MAX : sc0 + 3));
    check("mw_flush_d", 64'(flush_d), 64'(1));
    check("mw_flush_e", 64'(flush_e), 64'(1)); tick();
    clear_inputs();

    // Retire of an idle register sets the sticky error
    long_done = 1; long_rd = 9; cycle();
    long_done = 0;
    settle(); check("err_set", 64'(sb_err), 64'(1)); tick();
    cycle(); cycle();
    settle(); check("err_sticky", 64'(sb_err), 64'(1)); tick();

    // Asynchronous reset mid-cycle with long ops pending
    long_e = 1; rde = 11; cycle();
    rde = 12; cycle();
    long_e = 0; rde = 0;
    settle();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_vec), 64'(0));
    check("arst_err",  64'(sb_err), 64'(0));
    check("arst_sc",   64'(stall_cycles), 64'(0));
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rs1d = AW'($urandom_range(0, 7)); rs2d = AW'($urandom_range(0, 7));
      rdd  = AW'($urandom_range(0, 7)); regwrite_d = 1'($urandom_range(0, 1));
      long_d = ($urandom_range(0, 2) == 0);
      rs1e = AW'($urandom_range(0, 7)); rs2e = AW'($urandom_range(0, 7));
      resultsrc_e = 2'($urandom_range(0, 3)); pcsrc_e = ($urandom_range(0, 4) == 0);
      rdm = AW'($urandom_range(0, 7)); regwrite_m = 1'($urandom_range(0, 1));
      resultsrc_m = 2'($urandom_range(0, 3));
      rdw = AW'($urandom_range(0, 7)); regwrite_w = 1'($urandom_range(0, 1));
      mem_wait = ($urandom_range(0, 5) == 0);
      long_done = ($urandom_range(0, 3) == 0);
      long_rd = AW'($urandom_range(0, 7));
      // keep long-op issue legal: under the cap and never to an already-busy register
      long_e = 0; rde = AW'($urandom_range(0, 7));
      if (m_out < MAX_OUT && $urandom_range(0, 2) == 0) begin
        ok = 0;
        for (int t = 0; t < 8 && !ok; t++) begin
          pick = $urandom_range(0, 7);
          if (!m_busy[pick]) begin
            ok = 1; rde = AW'(pick);
          end
        end
        long_e = ok;
      end else if (m_busy[rde]) begin
        rde = 0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
